word_sync_ctrl: RTL

- Receive-side word-synchronisation controller for the 1000BASE-X style PCS path.
- Consumes the per-symbol comma-detect result (comma flag and 0..9 bit offset) and decides when to move the 10-bit word boundary.
- Drives the frozen offset to the downstream barrel shifter/bitslip logic and reports link sync status.
- Debounces acquisition over several commas and drops sync only after repeated errors, so single bit errors never cause a realign.

---
 rtl/word_sync_if.sv | 35 +++
 rtl/word_sync_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/word_sync_if.sv
// Symbol-side bus of the word-synchronisation controller: comma-detect inputs and alignment/status outputs.
// Optional statistics signals exist only when WORD_SYNC_STATS_EN is defined.
interface word_sync_if;
    logic       in_valid;
    logic       comma;
    logic [3:0] offset;
    logic       code_err;
    logic [3:0] align_offset;
    logic       realign;
    logic       sync_ok;
    logic [1:0] sync_state;
`ifdef WORD_SYNC_STATS_EN
    logic        stats_clr;
    logic [15:0] loss_events;
    logic [15:0] realign_events;
`endif

    modport master (
        output in_valid, comma, offset, code_err,
`ifdef WORD_SYNC_STATS_EN
        output stats_clr,
        input  loss_events, realign_events,
`endif
        input  align_offset, realign, sync_ok, sync_state
    );

    modport slave (
        input  in_valid, comma, offset, code_err,
`ifdef WORD_SYNC_STATS_EN
        input  stats_clr,
        output loss_events, realign_events,
`endif
        output align_offset, realign, sync_ok, sync_state
    );
endinterface

// File: rtl/word_sync_ctrl.sv
// Receive word-boundary synchronisation FSM: debounced comma acquisition, error hysteresis while synced.
// Define WORD_SYNC_STATS_EN to add saturating loss/realign event counters with a synchronous clear.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_LOSS   | no sync; first valid comma sets candidate offset
// ST_ACQ    | counting consecutive commas at the candidate offset
// ST_SYNCED | boundary frozen; bad/good symbol hysteresis decides loss
module word_sync_ctrl #(
    parameter int ACQ_COUNT    = 3,
    parameter int BAD_LIMIT    = 4,
    parameter int GOOD_RECOVER = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    word_sync_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_LOSS   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_SYNCED = 2'd2
    } state_t;

    localparam logic [3:0] ACQ_L  = 4'(ACQ_COUNT);
    localparam logic [3:0] BAD_L  = 4'(BAD_LIMIT);
    localparam logic [3:0] GOOD_L = 4'(GOOD_RECOVER);

    state_t     state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] acq_cnt_q, acq_cnt_d;
    logic [3:0] bad_cnt_q, bad_cnt_d;
    logic [3:0] good_cnt_q, good_cnt_d;
    logic [3:0] align_q, align_d;
    logic       realign_q, realign_d;
    logic       sync_ok_q, sync_ok_d;

    logic       comma_ok;
    logic       bad_sym;
    logic [3:0] acq_inc, bad_inc, good_inc;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Offsets 10..15 cannot be a real 10-bit boundary, so they count as no comma.
    assign comma_ok = bus.comma && (bus.offset <= 4'd9);
    assign bad_sym  = bus.code_err || (comma_ok && (bus.offset != align_q));
    assign acq_inc  = sat_inc(acq_cnt_q);
    assign bad_inc  = sat_inc(bad_cnt_q);
    assign good_inc = sat_inc(good_cnt_q);

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        acq_cnt_d  = acq_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        good_cnt_d = good_cnt_q;
        align_d    = align_q;
        realign_d  = 1'b0;
        if (bus.in_valid) begin
            case (state_q)
                ST_LOSS: begin
                    if (comma_ok) begin
                        cand_d    = bus.offset;
                        acq_cnt_d = 4'd1;
                        state_d   = ST_ACQ;
                        if (bus.offset != align_q) begin
                            align_d   = bus.offset;
                            realign_d = 1'b1;
                        end
                    end
                end
                ST_ACQ: begin
                    if (comma_ok) begin
                        if (bus.offset == cand_q) begin
                            if (acq_inc == ACQ_L) begin
                                state_d    = ST_SYNCED;
                                acq_cnt_d  = 4'd0;
                                bad_cnt_d  = 4'd0;
                                good_cnt_d = 4'd0;
                            end else begin
                                acq_cnt_d = acq_inc;
                            end
                        end else begin
                            cand_d    = bus.offset;
                            acq_cnt_d = 4'd1;
                            if (bus.offset != align_q) begin
                                align_d   = bus.offset;
                                realign_d = 1'b1;
                            end
                        end
                    end else if (bus.code_err) begin
                        state_d   = ST_LOSS;
                        acq_cnt_d = 4'd0;
                    end
                end
                ST_SYNCED: begin
                    if (bad_sym) begin
                        good_cnt_d = 4'd0;
                        if (bad_inc == BAD_L) begin
                            state_d   = ST_LOSS;
                            bad_cnt_d = 4'd0;
                            acq_cnt_d = 4'd0;
                        end else begin
                            bad_cnt_d = bad_inc;
                        end
                    end else if (good_inc == GOOD_L) begin
                        good_cnt_d = 4'd0;
                        if (bad_cnt_q != 4'd0) begin
                            bad_cnt_d = bad_cnt_q - 4'd1;
                        end
                    end else begin
                        good_cnt_d = good_inc;
                    end
                end
                default: state_d = ST_LOSS;
            endcase
        end
        sync_ok_d = (state_d == ST_SYNCED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_LOSS;
            cand_q     <= 4'd0;
            acq_cnt_q  <= 4'd0;
            bad_cnt_q  <= 4'd0;
            good_cnt_q <= 4'd0;
            align_q    <= 4'd0;
            realign_q  <= 1'b0;
            sync_ok_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            acq_cnt_q  <= acq_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            good_cnt_q <= good_cnt_d;
            align_q    <= align_d;
            realign_q  <= realign_d;
            sync_ok_q  <= sync_ok_d;
        end
    end

    assign bus.align_offset = align_q;
    assign bus.realign      = realign_q;
    assign bus.sync_ok      = sync_ok_q;
    assign bus.sync_state   = state_q;

`ifdef WORD_SYNC_STATS_EN
    logic [15:0] loss_ev_q, loss_ev_d;
    logic [15:0] realign_ev_q, realign_ev_d;
    logic        loss_inc;

    assign loss_inc = (state_q == ST_SYNCED) && (state_d == ST_LOSS);

    // Clear has priority over a coincident increment.
    always_comb begin
        loss_ev_d    = loss_ev_q;
        realign_ev_d = realign_ev_q;
        if (bus.stats_clr) begin
            loss_ev_d    = 16'd0;
            realign_ev_d = 16'd0;
        end else begin
            if (loss_inc && (loss_ev_q != 16'hFFFF)) begin
                loss_ev_d = loss_ev_q + 16'd1;
            end
            if (realign_d && (realign_ev_q != 16'hFFFF)) begin
                realign_ev_d = realign_ev_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loss_ev_q    <= 16'd0;
            realign_ev_q <= 16'd0;
        end else begin
            loss_ev_q    <= loss_ev_d;
            realign_ev_q <= realign_ev_d;
        end
    end

    assign bus.loss_events    = loss_ev_q;
    assign bus.realign_events = realign_ev_q;
`endif
endmodule
